rgmii_rx_gmii_adapter: RTL and testbench
========================================

# rgmii_rx_gmii_adapter

Receive-side RGMII-to-GMII adapter that consumes the rising/falling-edge sample pairs produced by the source-synchronous DDR input stage and presents a byte-wide GMII receive stream to the MAC. Runs entirely in the recovered receive clock domain. Handles 1000 Mb/s byte reconstruction, 10/100 Mb/s nibble pairing with a clock-enable strobe, and ctl-edge dv/er decode. Also extracts and filters RGMII in-band link status during inter-frame gaps.

## Interface
- STATUS_FILTER, 2: consecutive identical idle status samples required before status outputs update (1..15).
- clk  in  1  receive clock (DDR input stage output clock).
- rst_n  in  1  asynchronous active-low reset.
- speed  in  2  requested mode from MAC config: 00=10M, 01=100M, 10/11=1000M.
- rgmii_rx_q1  in  5  rising-edge sample: [3:0] rxd, [4] rx_ctl.
- rgmii_rx_q2  in  5  falling-edge sample: [3:0] rxd, [4] rx_ctl.
- gmii_rxd  out  8  received byte.
- gmii_rx_dv  out  1  data valid.
- gmii_rx_er  out  1  receive error.
- gmii_rx_valid  out  1  clock enable qualifying gmii_* (1 every cycle in 1000M, 1 every 2nd cycle in 10/100).
- link_up  out  1  filtered in-band link status.
- link_speed  out  2  filtered in-band speed (00/01/10).
- full_duplex  out  1  filtered in-band duplex.

## Operation
- Reset: all outputs 0; nibble state IDLE; effective mode = 1000M; filter counter 0.
- Stage 1 registers q1/q2 unconditionally. Decode: dv = q1[4], er = q1[4] ^ q2[4].
- Effective mode latched from speed only while not in a frame (dv=0 in stage 1 and nibble state IDLE). A speed change mid-frame takes effect on the first idle cycle after the frame ends.
- 1000M mode:
  - gmii_rxd = {q2[3:0], q1[3:0]}.
  - gmii_rx_dv = dv, gmii_rx_er = er, gmii_rx_valid = 1 every cycle.
- 10/100 mode: one nibble per cycle from q1[3:0]. States:
  - IDLE: valid toggles 1,0,1,0 with dv=0, rxd=0, er = er of that cycle (false carrier propagates). dv=1 → store low nibble and its er, go HIGH; this cycle outputs valid=0.
  - HIGH, dv=1 → output {q1[3:0], low}, dv=1, er = er_low | er_now, valid=1, go LOW.
  - HIGH, dv=0 (odd nibble count) → output {4'h0, low}, dv=1, er=1, valid=1, go IDLE.
  - LOW, dv=1 → store low nibble, go HIGH, valid=0.
  - LOW, dv=0 → go IDLE, output dv=0, valid=1 (frame-end gap byte).
  - Idle valid phase realigns at frame start; no valid=1 cycle is ever dropped or doubled inside a frame.
- In-band status sampled only on cycles with q1[4]=0 and q2[4]=0 (true idle), from q1[3:0]:
  - [0] link, [2:1] speed, [3] duplex.
  - Filter counter increments while the nibble equals the previous idle nibble, resets to 1 on change, and freezes (no reset) during frames and error cycles.
  - When counter reaches STATUS_FILTER, status outputs load the nibble and remain until a different nibble is qualified. Speed code 11 is loaded as 10.
- Status outputs are informational; they never change the effective mode (the MAC drives speed).

## Timing
- Inputs registered at edge k; GMII outputs update at edge k+1. 1000M latency is 2 cycles from input presentation.
- 10/100: low nibble registered at edge k, high nibble at k+1; byte with valid=1 appears after edge k+2.
- Status: the nibble held for STATUS_FILTER consecutive idle cycles appears on the outputs one edge after the qualifying sample is registered.
- Reset assertion clears all state immediately, mid-frame included; the first frame after release is decoded cleanly, with no stale nibble emitted.

## Test plan
- 1000M: q1=5'h15/q2=5'h1A (dv=1, er=0) for 4 cycles → gmii_rxd=8'hA5, dv=1, er=0, valid=1 on 4 cycles starting 2 edges later.
- 1000M error: q1[4]=1, q2[4]=0 for one cycle mid-frame → exactly that byte has er=1, dv=1.
- 100M: nibbles 5,A,3,C with ctl=1 → bytes 8'hA5 then 8'hC3, each with valid=1, valid=0 between them, no extra bytes.
- 100M odd frame: nibbles 1,2,3 then ctl=0 → bytes 8'h21 (er=0) then 8'h03 with er=1, then dv=0.
- Status: idle nibble 4'hD (link=1, speed=10, duplex=1) for STATUS_FILTER cycles → link_up=1, link_speed=2'b10, full_duplex=1; a single-cycle 4'h0 glitch → no change.
- Speed change from 10 to 1000 asserted mid-frame in 10M → frame completes in nibble mode; 1000M decode begins on the first idle cycle after it. rst_n pulse mid-frame → all outputs 0 at once.

Source files
------------

// File: rtl/rgmii_rx_gmii_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : rgmii_rx_gmii_adapter_if
// Description : Bundle of the RGMII sample-pair inputs, the MAC speed request,
//               the byte-wide GMII receive stream and the in-band link status.
//               master : the adapter (consumes samples, drives GMII/status)
//               slave  : the surrounding MAC / DDR stage (opposite directions)
// Ports       : speed[1:0]        requested mode 00=10M 01=100M 1x=1000M
//               rgmii_rx_q1[4:0]  rising-edge sample  {rx_ctl, rxd[3:0]}
//               rgmii_rx_q2[4:0]  falling-edge sample {rx_ctl, rxd[3:0]}
//               gmii_rxd[7:0], gmii_rx_dv, gmii_rx_er, gmii_rx_valid
//               link_up, link_speed[1:0], full_duplex
// Revision    : 1.0 - initial release
// ============================================================================
interface rgmii_rx_gmii_adapter_if;
  logic [1:0] speed;
  logic [4:0] rgmii_rx_q1;
  logic [4:0] rgmii_rx_q2;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       gmii_rx_valid;
  logic       link_up;
  logic [1:0] link_speed;
  logic       full_duplex;

  modport master (
    input  speed, rgmii_rx_q1, rgmii_rx_q2,
    output gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid,
           link_up, link_speed, full_duplex
  );

  modport slave (
    output speed, rgmii_rx_q1, rgmii_rx_q2,
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid,
           link_up, link_speed, full_duplex
  );
endinterface
`default_nettype wire

// File: rtl/rgmii_rx_gmii_adapter.sv
`default_nettype none
// ============================================================================
// Module      : rgmii_rx_gmii_adapter
// Description : RGMII receive sample pairs to GMII byte stream. Rebuilds bytes
//               directly at 1000M, pairs nibbles with a clock-enable strobe at
//               10/100M, decodes dv/er from rx_ctl, and filters the in-band
//               link status carried on true-idle inter-frame cycles.
// Parameters  : STATUS_FILTER - identical idle status samples needed before
//               the status outputs update (1..15)
// Ports       : clk   - receive clock (DDR input stage output clock)
//               rst_n - asynchronous active-low reset
//               bus   - rgmii_rx_gmii_adapter_if.master (samples in, GMII and
//                       link status out)
// Revision    : 1.0 - initial release
// ============================================================================
module rgmii_rx_gmii_adapter #(
  parameter int STATUS_FILTER = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  rgmii_rx_gmii_adapter_if.master         bus
);

  localparam logic [3:0] FILT_CNT = 4'(STATUS_FILTER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } nib_state_t;

  // stage 1 sample registers
  logic [4:0] q1_q, q2_q;

  // mode and nibble pairing state
  logic [1:0] mode_q, mode_d;
  nib_state_t state_q, state_d;
  logic [3:0] low_q, low_d;
  logic       er_low_q, er_low_d;
  logic       phase_q, phase_d;

  // GMII output registers
  logic [7:0] rxd_q, rxd_d;
  logic       dv_q, dv_d;
  logic       er_q, er_d;
  logic       valid_q, valid_d;

  // in-band status filter
  logic [3:0] prev_q, prev_d;
  logic [3:0] cnt_q, cnt_d;
  logic       link_q, link_d;
  logic [1:0] lspd_q, lspd_d;
  logic       dup_q, dup_d;

  logic       s1_dv, s1_er, s1_idle, gig;
  logic [3:0] nib;

  assign s1_dv   = q1_q[4];
  assign s1_er   = q1_q[4] ^ q2_q[4];
  assign s1_idle = ~q1_q[4] & ~q2_q[4];
  assign nib     = q1_q[3:0];
  assign gig     = (mode_q == 2'b10) || (mode_q == 2'b11);

  always_comb begin
    state_d  = state_q;
    low_d    = low_q;
    er_low_d = er_low_q;
    phase_d  = phase_q;
    rxd_d    = rxd_q;
    dv_d     = dv_q;
    er_d     = er_q;
    valid_d  = 1'b0;

    // Only resample the MAC's request between frames so a frame is never
    // split across two decode modes.
    mode_d = (!s1_dv && state_q == ST_IDLE) ? bus.speed : mode_q;

    if (gig) begin
      rxd_d   = {q2_q[3:0], q1_q[3:0]};
      dv_d    = s1_dv;
      er_d    = s1_er;
      valid_d = 1'b1;
      state_d = ST_IDLE;
      phase_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s1_dv) begin
            // frame start: the idle strobe phase is discarded here
            low_d    = nib;
            er_low_d = s1_er;
            state_d  = ST_HIGH;
            rxd_d    = 8'h00;
            dv_d     = 1'b0;
            er_d     = 1'b0;
          end else begin
            // er passes through so a false carrier reaches the MAC
            rxd_d   = 8'h00;
            dv_d    = 1'b0;
            er_d    = s1_er;
            valid_d = phase_q;
            phase_d = ~phase_q;
          end
        end
        ST_HIGH: begin
          valid_d = 1'b1;
          dv_d    = 1'b1;
          if (s1_dv) begin
            rxd_d   = {nib, low_q};
            er_d    = er_low_q | s1_er;
            state_d = ST_LOW;
          end else begin
            // odd nibble count: flush the half byte flagged as errored
            rxd_d   = {4'h0, low_q};
            er_d    = 1'b1;
            state_d = ST_IDLE;
            phase_d = 1'b0;
          end
        end
        ST_LOW: begin
          if (s1_dv) begin
            low_d    = nib;
            er_low_d = s1_er;
            state_d  = ST_HIGH;
          end else begin
            // gap byte closing the frame; next idle strobe is low
            rxd_d   = 8'h00;
            dv_d    = 1'b0;
            er_d    = s1_er;
            valid_d = 1'b1;
            state_d = ST_IDLE;
            phase_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    link_d = link_q;
    lspd_d = lspd_q;
    dup_d  = dup_q;
    // frames and error cycles leave the filter frozen
    if (s1_idle) begin
      prev_d = nib;
      if (nib == prev_q) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
      if (cnt_d == FILT_CNT) begin
        link_d = nib[0];
        lspd_d = (nib[2:1] == 2'b11) ? 2'b10 : nib[2:1];
        dup_d  = nib[3];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q     <= 5'd0;
      q2_q     <= 5'd0;
      mode_q   <= 2'b10;
      state_q  <= ST_IDLE;
      low_q    <= 4'd0;
      er_low_q <= 1'b0;
      phase_q  <= 1'b0;
      rxd_q    <= 8'd0;
      dv_q     <= 1'b0;
      er_q     <= 1'b0;
      valid_q  <= 1'b0;
      prev_q   <= 4'd0;
      cnt_q    <= 4'd0;
      link_q   <= 1'b0;
      lspd_q   <= 2'b00;
      dup_q    <= 1'b0;
    end else begin
      q1_q     <= bus.rgmii_rx_q1;
      q2_q     <= bus.rgmii_rx_q2;
      mode_q   <= mode_d;
      state_q  <= state_d;
      low_q    <= low_d;
      er_low_q <= er_low_d;
      phase_q  <= phase_d;
      rxd_q    <= rxd_d;
      dv_q     <= dv_d;
      er_q     <= er_d;
      valid_q  <= valid_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      link_q   <= link_d;
      lspd_q   <= lspd_d;
      dup_q    <= dup_d;
    end
  end

  assign bus.gmii_rxd      = rxd_q;
  assign bus.gmii_rx_dv    = dv_q;
  assign bus.gmii_rx_er    = er_q;
  assign bus.gmii_rx_valid = valid_q;
  assign bus.link_up       = link_q;
  assign bus.link_speed    = lspd_q;
  assign bus.full_duplex   = dup_q;

endmodule
`default_nettype wire

// File: tb/tb_rgmii_rx_gmii_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgmii_rx_gmii_adapter
// Description : Self-checking bench for rgmii_rx_gmii_adapter. Frame bytes are
//               queued as expected {er, rxd} when driven and popped whenever
//               the adapter presents valid && dv; status and reset behaviour
//               are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgmii_rx_gmii_adapter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [8:0] exp_q[$];
  logic nib_chk = 1'b0;
  logic prev_vdv = 1'b0;
  logic [3:0] idle_nib = 4'h0;

  rgmii_rx_gmii_adapter_if bus();

  rgmii_rx_gmii_adapter #(.STATUS_FILTER(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gmii_rx_valid && bus.gmii_rx_dv) begin
        logic [8:0] e;
        check("sb_byte_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_rxd", int'(bus.gmii_rxd), int'(e[7:0]));
          check("sb_rx_er", int'(bus.gmii_rx_er), int'(e[8]));
        end
        if (nib_chk) check("nib_gap", int'(prev_vdv), 0);
      end
      prev_vdv = bus.gmii_rx_valid && bus.gmii_rx_dv;
    end else begin
      prev_vdv = 1'b0;
    end
  end

  task automatic tick(input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    bus.rgmii_rx_q1 = a;
    bus.rgmii_rx_q2 = b;
  endtask

  task automatic idle(input int n);
    repeat (n) tick({1'b0, idle_nib}, {1'b0, idle_nib});
  endtask

  task automatic gig_byte(input logic [7:0] b, input logic err);
    tick({1'b1, b[3:0]}, {~err, b[7:4]});
    exp_q.push_back({err, b});
  endtask

  task automatic nib(input logic [3:0] n);
    tick({1'b1, n}, {1'b1, n});
  endtask

  // nibbles taken LSB-first from nibs, then one ctl=0 cycle
  task automatic nib_frame(input logic [31:0] nibs, input int n);
    logic [3:0] lo;
    logic [3:0] cur;
    lo = 4'h0;
    for (int i = 0; i < n; i++) begin
      cur = nibs[4*i +: 4];
      nib(cur);
      if (i % 2 == 1) exp_q.push_back({1'b0, cur, lo});
      else lo = cur;
    end
    idle(1);
    if (n % 2 == 1) exp_q.push_back({1'b1, 4'h0, lo});
  endtask

  task automatic drain(input string tag);
    idle(8);
    check(tag, int'(exp_q.size()), 0);
  endtask

  task automatic check_all_zero();
    check("rst_rxd", int'(bus.gmii_rxd), 0);
    check("rst_dv", int'(bus.gmii_rx_dv), 0);
    check("rst_er", int'(bus.gmii_rx_er), 0);
    check("rst_valid", int'(bus.gmii_rx_valid), 0);
    check("rst_link", int'(bus.link_up), 0);
    check("rst_lspd", int'(bus.link_speed), 0);
    check("rst_dup", int'(bus.full_duplex), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v1;
    logic v2;
    rst_n = 1'b1;
    bus.speed = 2'b10;
    bus.rgmii_rx_q1 = 5'h00;
    bus.rgmii_rx_q2 = 5'h00;
    #2 rst_n = 1'b0;
    #1 check_all_zero();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ---- 1000M: latency and steady A5 bytes ----
    idle(4);
    check("gig_idle_valid", int'(bus.gmii_rx_valid), 1);
    gig_byte(8'hA5, 1'b0);
    gig_byte(8'hA5, 1'b0);
    check("gig_lat_early", int'(bus.gmii_rx_dv), 0);
    gig_byte(8'hA5, 1'b0);
    check("gig_lat_dv", int'(bus.gmii_rx_dv), 1);
    check("gig_lat_rxd", int'(bus.gmii_rxd), 8'hA5);
    gig_byte(8'hA5, 1'b0);
    idle(2);
    // single errored byte mid-frame
    gig_byte(8'h11, 1'b0);
    gig_byte(8'h22, 1'b1);
    gig_byte(8'h33, 1'b0);
    drain("gig_drain");

    // ---- 100M nibble pairing ----
    bus.speed = 2'b01;
    idle(4);
    nib_chk = 1'b1;
    @(negedge clk) v1 = bus.gmii_rx_valid;
    @(negedge clk) v2 = bus.gmii_rx_valid;
    check("idle_toggle", int'(v1 ^ v2), 1);
    nib_frame(32'h0000_C3A5, 4);
    drain("nib_even_drain");
    nib_frame(32'h0000_0321, 3);
    drain("nib_odd_drain");

    // ---- speed change mid-frame in 10M ----
    bus.speed = 2'b00;
    idle(4);
    nib(4'h6);
    nib(4'h7);
    exp_q.push_back({1'b0, 8'h76});
    bus.speed = 2'b10;
    nib(4'h8);
    nib(4'h9);
    exp_q.push_back({1'b0, 8'h98});
    idle(1);
    drain("spdchg_nib_drain");
    nib_chk = 1'b0;
    gig_byte(8'h5A, 1'b0);
    gig_byte(8'hC3, 1'b0);
    drain("spdchg_gig_drain");

    // ---- in-band status filter ----
    check("st_init_link", int'(bus.link_up), 0);
    idle_nib = 4'hD;
    idle(3);
    check("st_early_link", int'(bus.link_up), 0);
    idle(1);
    check("st_link", int'(bus.link_up), 1);
    check("st_speed", int'(bus.link_speed), 2'b10);
    check("st_duplex", int'(bus.full_duplex), 1);
    idle_nib = 4'h0;
    idle(1);
    idle_nib = 4'hD;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("st_glitch_link", int'(bus.link_up), 1);
      check("st_glitch_dup", int'(bus.full_duplex), 1);
    end
    idle_nib = 4'h7;
    idle(4);
    check("st_spd11_speed", int'(bus.link_speed), 2'b10);
    check("st_spd11_dup", int'(bus.full_duplex), 0);
    check("st_spd11_link", int'(bus.link_up), 1);

    // ---- reset mid-frame, then clean frame ----
    bus.speed = 2'b01;
    idle(4);
    nib_chk = 1'b1;
    nib(4'h1);
    nib(4'h2);
    nib(4'h3);
    #2 rst_n = 1'b0;
    #1 check_all_zero();
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(4);
    nib_frame(32'h0000_7654, 4);
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
